// File: rtl/param_queue_pkg.sv
// Shared queue constants and helpers.
// Width/depth defaults, FWFT mode codes, pointer sizing.
package param_queue_pkg;

  localparam int QUEUE_WIDTH = 256;
  localparam int QUEUE_DEPTH = 16;

  localparam int FWFT_REG  = 0;
  localparam int FWFT_FALL = 1;

  // Bits needed to address v entries.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/queue_ram.sv
// Queue storage: one sync write port, one async read port.
// Contents are never reset.
module queue_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_queue.sv
// Parameterised synchronous queue.
// Pointers, occupancy, flags and read path; storage in queue_ram.
module param_queue
  import param_queue_pkg::*;
#(
  parameter int WIDTH    = QUEUE_WIDTH,
  parameter int DEPTH    = QUEUE_DEPTH,
  parameter int FWFT     = FWFT_REG,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("param_queue: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("param_queue: AF_LEVEL exceeds DEPTH");
  end

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;
  logic             unf_q;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;

  // A full queue still takes a push when a pop frees a slot.
  assign pop  = rd_en & ~empty;
  assign push = wr_en & (~full | pop);

  assign count        = cnt_q;
  assign full         = (cnt_q == CW'(DEPTH));
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= CW'(AF_LEVEL));
  assign almost_empty = (cnt_q <= CW'(AE_LEVEL));
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // Pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push & ~pop: cnt_q <= cnt_q + 1'b1;
        pop & ~push: cnt_q <= cnt_q - 1'b1;
        default:     cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky error flags, cleared only by flush or reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_en & ~push) ovf_q <= 1'b1;
      if (rd_en & ~pop)  unf_q <= 1'b1;
    end
  end

  queue_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push & ~clr),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  if (FWFT != FWFT_REG) begin : g_fwft
    assign rd_data  = empty ? '0 : head;
    assign rd_valid = ~empty;
  end else begin : g_reg
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    // Registered read: capture head on each accepted pop.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (clr) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= pop;
        if (pop) data_q <= head;
      end
    end

    assign rd_data  = data_q;
    assign rd_valid = valid_q;
  end

endmodule
